// File: rtl/masked_vector_regfile.sv
`timescale 1ns/1ps
// Vector register file with per-lane write masks, NUM_RD combinational read ports, a word-wide host port and a clear sequencer.
// Latency: reads combinational, compute/host writes land on the next edge, host read data 1 cycle. Define VRF_BYPASS_EN for same-cycle write forwarding.
// Backpressure: host_req_ready drops while clearing, during a compute write, or when clr is asserted.
module masked_vector_regfile #(
  parameter int LEN        = 16,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD     = 3,
  parameter int LANE_W     = 4
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         clr,
  output logic                                         init_done,
  input  logic                                         en,
  input  logic [ADDR_WIDTH-1:0]                        addr_w,
  input  logic [LEN-1:0]                               mask_w,
  input  logic [LEN-1:0][DATA_WIDTH-1:0]               data_w,
  input  logic [NUM_RD-1:0][ADDR_WIDTH-1:0]            addr_r,
  output logic [NUM_RD-1:0][LEN-1:0][DATA_WIDTH-1:0]   data_r,
  input  logic                                         host_req_valid,
  output logic                                         host_req_ready,
  input  logic                                         host_we,
  input  logic [ADDR_WIDTH-1:0]                        host_addr,
  input  logic [LANE_W-1:0]                            host_lane,
  input  logic [DATA_WIDTH-1:0]                        host_wdata,
  output logic                                         host_rvalid,
  output logic [DATA_WIDTH-1:0]                        host_rdata
);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   clr_cnt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH][LEN];

  logic host_acc;
  logic host_rd;
  logic host_wr;
  logic cmp_wr;

  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return 32'(a) < 32'(DEPTH);
  endfunction

  function automatic logic lane_ok(input logic [LANE_W-1:0] l);
    return 32'(l) < 32'(LEN);
  endfunction

  // Compute port has strict priority; clr also blocks the host so nothing is accepted into a dropped cycle.
  assign host_req_ready = (state == ST_READY) && !en && !clr;
  assign host_acc       = host_req_valid && host_req_ready;
  assign host_rd        = host_acc && !host_we;
  assign host_wr        = host_acc && host_we && addr_ok(host_addr) && lane_ok(host_lane);
  assign cmp_wr         = (state == ST_READY) && en && !clr && addr_ok(addr_w);

  // Storage has no reset; the clear sequencer zeroes it one register per cycle instead.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      for (int i = 0; i < LEN; i++) begin
        mem[clr_cnt][i] <= '0;
      end
    end else if (cmp_wr) begin
      for (int i = 0; i < LEN; i++) begin
        if (mask_w[i]) begin
          mem[addr_w][i] <= data_w[i];
        end
      end
    end else if (host_wr) begin
      mem[host_addr][host_lane] <= host_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_CLEAR;
      clr_cnt     <= '0;
      init_done   <= 1'b0;
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
    end else begin
      host_rvalid <= host_rd;
      if (host_rd) begin
        host_rdata <= (addr_ok(host_addr) && lane_ok(host_lane)) ? mem[host_addr][host_lane] : '0;
      end
      case (state)
        ST_CLEAR: begin
          if (clr_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
            state     <= ST_READY;
            clr_cnt   <= '0;
            init_done <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
          end
        end
        ST_READY: begin
          if (clr) begin
            state     <= ST_CLEAR;
            clr_cnt   <= '0;
            init_done <= 1'b0;
          end
        end
        default: begin
          state     <= ST_CLEAR;
          clr_cnt   <= '0;
          init_done <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    data_r = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if ((state == ST_READY) && addr_ok(addr_r[k])) begin
        for (int i = 0; i < LEN; i++) begin
          data_r[k][i] = mem[addr_r[k]][i];
`ifdef VRF_BYPASS_EN
          if (cmp_wr && (addr_r[k] == addr_w) && mask_w[i]) begin
            data_r[k][i] = data_w[i];
          end
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_masked_vector_regfile.sv
`timescale 1ns/1ps
// Randomized scoreboard bench for masked_vector_regfile against an array-based reference model.
module tb_masked_vector_regfile;

  localparam int LEN = 16, DW = 32, DEPTH = 32, AW = 5, NRD = 3, LW = 4;

  logic                          clk = 1'b0;
  logic                          rst_n = 1'b0;
  logic                          clr = 1'b0;
  logic                          init_done;
  logic                          en = 1'b0;
  logic [AW-1:0]                 addr_w = '0;
  logic [LEN-1:0]                mask_w = '0;
  logic [LEN-1:0][DW-1:0]        data_w = '0;
  logic [NRD-1:0][AW-1:0]        addr_r = '0;
  logic [NRD-1:0][LEN-1:0][DW-1:0] data_r;
  logic                          host_req_valid = 1'b0;
  logic                          host_req_ready;
  logic                          host_we = 1'b0;
  logic [AW-1:0]                 host_addr = '0;
  logic [LW-1:0]                 host_lane = '0;
  logic [DW-1:0]                 host_wdata = '0;
  logic                          host_rvalid;
  logic [DW-1:0]                 host_rdata;

  masked_vector_regfile #(
    .LEN(LEN), .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .NUM_RD(NRD), .LANE_W(LW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .init_done(init_done),
    .en(en), .addr_w(addr_w), .mask_w(mask_w), .data_w(data_w),
    .addr_r(addr_r), .data_r(data_r),
    .host_req_valid(host_req_valid), .host_req_ready(host_req_ready),
    .host_we(host_we), .host_addr(host_addr), .host_lane(host_lane),
    .host_wdata(host_wdata), .host_rvalid(host_rvalid), .host_rdata(host_rdata)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Reference model: plain array contents plus a count of remaining clear cycles.
  logic [DW-1:0] model [DEPTH][LEN];
  int            clear_left = DEPTH;
  bit            model_ready = 1'b0;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } rd_t;
  rd_t rdq[$];

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic start_clear();
    for (int r = 0; r < DEPTH; r++)
      for (int l = 0; l < LEN; l++) model[r][l] = '0;
    clear_left  = DEPTH;
    model_ready = 1'b0;
  endtask

  // Checks current outputs against the model mid-cycle, then advances the model across the next edge.
  task automatic tick();
    logic [LEN-1:0][DW-1:0] ev;
    @(negedge clk);
    check("init_done", DW'(init_done), DW'(model_ready));
    check("host_req_ready", DW'(host_req_ready), DW'(model_ready && !en && !clr));
    for (int k = 0; k < NRD; k++) begin
      for (int l = 0; l < LEN; l++) begin
        ev[l] = model_ready ? model[int'(addr_r[k])][l] : '0;
`ifdef VRF_BYPASS_EN
        if (model_ready && en && !clr && addr_r[k] == addr_w && mask_w[l]) ev[l] = data_w[l];
`endif
      end
      checks++;
      if (data_r[k] !== ev) begin
        errors++;
        $display("FAIL data_r[%0d] addr %0d: got %h expected %h", k, addr_r[k], data_r[k], ev);
      end
    end
    if (!model_ready) begin
      clear_left--;
      model_ready = (clear_left == 0);
    end else if (clr) begin
      start_clear();
    end else if (en) begin
      for (int l = 0; l < LEN; l++)
        if (mask_w[l]) model[int'(addr_w)][l] = data_w[l];
    end else if (host_req_valid) begin
      if (host_we) begin
        if (int'(host_lane) < LEN) model[int'(host_addr)][int'(host_lane)] = host_wdata;
      end else begin
        rdq.push_back('{data: (int'(host_lane) < LEN) ? model[int'(host_addr)][int'(host_lane)] : '0,
                        due: cyc + 1});
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Host read monitor: pops the expected word whenever the DUT presents host_rvalid.
  always @(negedge clk) begin
    if (rst_n) begin
      if (host_rvalid) begin
        checks++;
        if (rdq.size() == 0) begin
          errors++;
          $display("FAIL host_rvalid: got unexpected pulse at cycle %0d expected none", cyc);
        end else begin
          rd_t r;
          r = rdq.pop_front();
          if (r.due != cyc || host_rdata !== r.data) begin
            errors++;
            $display("FAIL host_rdata: got %h at cycle %0d expected %h at cycle %0d",
                     host_rdata, cyc, r.data, r.due);
          end
        end
      end else if (rdq.size() > 0 && rdq[0].due <= cyc) begin
        rd_t r;
        r = rdq.pop_front();
        checks++;
        errors++;
        $display("FAIL host_rvalid: got 0 at cycle %0d expected pulse with %h", cyc, r.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    en = 1'b0; clr = 1'b0; host_req_valid = 1'b0; mask_w = '0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst init_done", DW'(init_done), '0);
    check("rst host_req_ready", DW'(host_req_ready), '0);
    check("rst host_rvalid", DW'(host_rvalid), '0);
    check("rst host_rdata", host_rdata, '0);
    rst_n = 1'b1;
    start_clear();

    // Clear sequence: host_req_valid held high to confirm nothing is accepted
    addr_r[0] = 7;
    host_req_valid = 1'b1; host_we = 1'b1; host_addr = 7; host_lane = 0; host_wdata = 32'hffffffff;
    repeat (DEPTH) tick();
    idle();
    tick();
    check("reg7 after clear", data_r[0][0], '0);

    // Masked compute write
    en = 1'b1; addr_w = 3; mask_w = 16'h0005;
    for (int l = 0; l < LEN; l++) data_w[l] = 32'h3f800000;
    tick();
    idle(); addr_r[0] = 3;
    #2;
    check("reg3 lane0", data_r[0][0], 32'h3f800000);
    check("reg3 lane1", data_r[0][1], 32'h0);
    check("reg3 lane2", data_r[0][2], 32'h3f800000);
    tick();

    // Host write then read of the same word
    host_req_valid = 1'b1; host_we = 1'b1; host_addr = 2; host_lane = 6; host_wdata = 32'h3b6d8000;
    tick();
    host_we = 1'b0;
    tick();
    idle();
    check("host rvalid", DW'(host_rvalid), 32'h1);
    check("host rdata", host_rdata, 32'h3b6d8000);
    tick();

    // Compute priority over host
    en = 1'b1; addr_w = 9; mask_w = '0;
    host_req_valid = 1'b1; host_we = 1'b1; host_addr = 4; host_lane = 1; host_wdata = 32'hdeadbeef;
    addr_r[2] = 4;
    tick();
    en = 1'b0;
    #2;
    check("host blocked", data_r[2][1], 32'h0);
    tick();
    idle();
    #2;
    check("host applied", data_r[2][1], 32'hdeadbeef);
    tick();

    // Same-cycle forwarding
    addr_r[1] = 5; en = 1'b1; addr_w = 5; mask_w = 16'h0001; data_w[0] = 32'hc11cf5c3;
    #2;
`ifdef VRF_BYPASS_EN
    check("bypass lane0", data_r[1][0], 32'hc11cf5c3);
`else
    check("no bypass lane0", data_r[1][0], 32'h0);
`endif
    tick();
    idle();
    #2;
    check("reg5 lane0 next", data_r[1][0], 32'hc11cf5c3);
    tick();

    // clr after loading reg 1, then rst_n mid-clear
    en = 1'b1; addr_w = 1; mask_w = '1;
    for (int l = 0; l < LEN; l++) data_w[l] = 32'h12345600 + l;
    tick();
    idle(); clr = 1'b1;
    tick();
    clr = 1'b0; addr_r[0] = 1;
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    check("mid rst init_done", DW'(init_done), '0);
    check("mid rst host_rdata", host_rdata, '0);
    check("mid rst host_rvalid", DW'(host_rvalid), '0);
    #1;
    rst_n = 1'b1;
    start_clear();
    repeat (DEPTH) tick();
    #1;
    check("reg1 cleared", data_r[0][0], '0);
    check("init_done after clear", DW'(init_done), 32'h1);
    tick();

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      en = ($urandom_range(9) < 3);
      addr_w = AW'($urandom);
      case ($urandom_range(3))
        0: mask_w = '0;
        1: mask_w = '1;
        default: mask_w = LEN'($urandom);
      endcase
      for (int l = 0; l < LEN; l++) data_w[l] = $urandom;
      for (int k = 0; k < NRD; k++) addr_r[k] = AW'($urandom);
      host_req_valid = ($urandom_range(9) < 6);
      host_we = $urandom_range(1);
      host_addr = AW'($urandom);
      host_lane = LW'($urandom);
      host_wdata = $urandom;
      clr = model_ready && ($urandom_range(99) == 0);
      tick();
    end
    idle();
    repeat (3) tick();
    check("pending reads", rdq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
